// File: rtl/imem_boot_loader_if.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_if
// Groups the loader's two bus-style connections:
//   - host word stream : in_valid, in_data[31:0], in_ready
//   - imem write port  : mem_we, mem_addr[ADDR_WIDTH-1:0], mem_wdata[7:0]
// Modports:
//   slave  - the loader (consumes the word stream, drives the memory port)
//   master - the surrounding system (produces words, observes memory writes)
// -----------------------------------------------------------------------------
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  in_valid;
  logic [31:0]           in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Fills a byte-wide instruction memory from a 32-bit word stream and holds the
// CPU in reset until the image is complete. Each accepted word is written as
// four little-endian bytes at consecutive addresses, so a fetch of
// {mem[a+3],mem[a+2],mem[a+1],mem[a]} returns the original word.
//
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   start             - single-cycle load request (honoured in IDLE/DONE only)
//   length_words      - words to load, sampled on an accepted start
//   bus (slave)       - word stream in, byte write port out
//   busy              - load in progress
//   done / error      - level status of the last load (success / rejected)
//   cpu_run           - CPU reset release, high in DONE
//   checksum          - mod-2^32 sum of accepted words
//
// Optional feature macro: IMEM_BOOT_LOADER_CHECKSUM_EN
//   defined   - checksum accumulates the words of the current load
//   undefined - checksum is tied to 0 and no accumulator exists
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-2:0] length_words,
  imem_boot_loader_if.slave     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_run,
  output logic [31:0]           checksum
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Memory capacity in words, expressed in the length port width.
  localparam logic [ADDR_WIDTH-2:0] CAP_WORDS = {1'b1, {(ADDR_WIDTH-2){1'b0}}};

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    return w[8*k +: 8];
  endfunction

  state_t                state;
  logic [ADDR_WIDTH-2:0] len_q;
  logic [ADDR_WIDTH-2:0] cnt_q;
  logic [ADDR_WIDTH-2:0] cnt_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [1:0]            k_q;
  logic [31:0]           word_q;
  logic                  in_ready_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [7:0]            mem_wdata_q;
  logic                  accept;

  // in_ready is a registered state flag, so the handshake never loops back
  // through in_valid.
  assign accept  = in_ready_q & bus.in_valid;
  assign cnt_nxt = cnt_q + (ADDR_WIDTH-1)'(1);

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Captured word; pure data, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) word_q <= bus.in_data;
  end

  // Control FSM. mem_we/addr/wdata are registered: the accept edge already
  // loads byte 0, and k_q tracks the byte currently on the write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_run     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (length_words == '0) begin
              state   <= DONE;
              done    <= 1'b1;
              error   <= 1'b0;
              cpu_run <= 1'b1;
            end else if (length_words > CAP_WORDS) begin
              state   <= DONE;
              done    <= 1'b0;
              error   <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state      <= WAIT_WORD;
              len_q      <= length_words;
              cnt_q      <= '0;
              base_q     <= '0;
              busy       <= 1'b1;
              in_ready_q <= 1'b1;
              done       <= 1'b0;
              error      <= 1'b0;
              cpu_run    <= 1'b0;
            end
          end
        end

        WAIT_WORD: begin
          if (accept) begin
            state       <= WRITE;
            in_ready_q  <= 1'b0;
            k_q         <= 2'd0;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= base_q;
            mem_wdata_q <= bus.in_data[7:0];
          end
        end

        WRITE: begin
          if (k_q != 2'd3) begin
            k_q         <= k_q + 2'd1;
            mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(1);
            mem_wdata_q <= byte_sel(word_q, k_q + 2'd1);
          end else begin
            // Last byte of the word is on the port this cycle. base_q may
            // wrap after a full-capacity load, but it is never used again.
            mem_we_q <= 1'b0;
            base_q   <= base_q + ADDR_WIDTH'(4);
            cnt_q    <= cnt_nxt;
            if (cnt_nxt == len_q) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              state      <= WAIT_WORD;
              in_ready_q <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  logic        start_ok;
  logic [31:0] sum_q;

  assign start_ok = start & ((state == IDLE) | (state == DONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (start_ok) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + bus.in_data;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Randomised scenario bench for imem_boot_loader. The reference model is the
// image array img[]: byte i of the load must land at address i with value
// img[i/4] >> 8*(i%4); the expected checksum is the plain sum of the image.
// -----------------------------------------------------------------------------
module tb_imem_boot_loader;
  localparam int AW  = 10;
  localparam int CAP = 256;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-2:0] length_words;
  logic          busy, done, error, cpu_run;
  logic [31:0]   checksum;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_WIDTH(AW)) mif ();

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .length_words (length_words),
    .bus          (mif),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_run      (cpu_run),
    .checksum     (checksum)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0]   img [0:CAP];
  logic [AW-1:0] wa_q [$];
  logic [7:0]    wd_q [$];
  int            last_we_cyc;
  int            done_cyc;
  int            overlap_cnt;
  int            runbusy_cnt;
  int            cpu_low_cnt;

  always @(posedge clk) cyc++;

  // Passive observer of the memory port and status relationships.
  always @(negedge clk) begin
    if (mif.mem_we) begin
      wa_q.push_back(mif.mem_addr);
      wd_q.push_back(mif.mem_wdata);
      last_we_cyc = cyc;
    end
    if (mif.in_ready && mif.mem_we) overlap_cnt++;
    if (mif.in_ready && !busy)      overlap_cnt++;
    if (busy && cpu_run)            runbusy_cnt++;
    if (busy && !cpu_run)           cpu_low_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang want finish");
    $fatal(1);
  end

  // Reference model: number of observed byte writes disagreeing with the image.
  function automatic int bad_writes(input int n);
    int bad = 0;
    for (int i = 0; i < 4 * n && i < wa_q.size(); i++) begin
      logic [31:0] w;
      logic [7:0]  b;
      w = img[i / 4] >> (8 * (i % 4));
      b = w[7:0];
      if (wa_q[i] !== AW'(i) || wd_q[i] !== b) bad++;
    end
    return bad;
  endfunction

  function automatic logic [31:0] exp_sum(input int n);
    logic [31:0] s = 32'd0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    for (int i = 0; i < n; i++) s = s + img[i];
`endif
    return s;
  endfunction

  // Runs one load of img[0..n-1]. vpct: percent chance in_valid is high in a
  // cycle. poke: pulse start (length 0) while the load is in progress.
  task automatic do_load(input int n, input int vpct, input bit poke, output bit ok);
    int idx    = 0;
    int budget = 0;
    int lim    = 40 * n + 40;
    bit acc;
    wa_q.delete();
    wd_q.delete();
    overlap_cnt = 0;
    runbusy_cnt = 0;
    cpu_low_cnt = 0;
    start        = 1'b1;
    length_words = (AW-1)'(n);
    @(negedge clk);
    start = 1'b0;
    while (idx < n && budget < lim) begin
      mif.in_valid = ($urandom_range(99) < vpct);
      mif.in_data  = mif.in_valid ? img[idx] : $urandom;
      acc = mif.in_valid && mif.in_ready;
      if (poke && budget == 3) begin
        start        = 1'b1;
        length_words = '0;
      end
      @(negedge clk);
      start = 1'b0;
      if (acc) idx++;
      budget++;
    end
    mif.in_valid = 1'b0;
    mif.in_data  = $urandom;
    while (!done && budget < lim) begin
      @(negedge clk);
      budget++;
    end
    done_cyc = cyc;
    ok = done;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    start        = 1'b0;
    length_words = '0;
    mif.in_valid = 1'b0;
    mif.in_data  = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({mif.in_ready, mif.mem_we, mif.mem_addr, mif.mem_wdata, busy, done, error, cpu_run, checksum} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0h wd=%0h busy=%b done=%b err=%b run=%b sum=%0h want all 0",
               mif.in_ready, mif.mem_we, mif.mem_addr, mif.mem_wdata, busy, done, error, cpu_run, checksum);
    end
    mif.in_valid = 1'b1;
    mif.in_data  = 32'h1234_5678;
    repeat (3) @(negedge clk);
    mif.in_valid = 1'b0;
    n_vec++;
    if ({mif.in_ready, mif.mem_we, busy, cpu_run} !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_ignores_valid: got rdy/we/busy/run=%b want 0000", {mif.in_ready, mif.mem_we, busy, cpu_run});
    end
  endtask

  task automatic test_basic();
    bit ok;
    img[0] = 32'h0000_0013;
    img[1] = 32'hDEAD_BEEF;
    do_load(2, 100, 1'b0, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL basic_timeout: got done=%b want 1", ok); end
    n_vec++;
    if (wa_q.size() !== 8) begin n_err++; $display("FAIL basic_count: got %0d want 8", wa_q.size()); end
    n_vec++;
    if (bad_writes(2) !== 0) begin n_err++; $display("FAIL basic_bytes: got %0d bad writes want 0", bad_writes(2)); end
    n_vec++;
    if (done_cyc !== last_we_cyc + 1) begin
      n_err++;
      $display("FAIL basic_done_latency: got cycle %0d want %0d", done_cyc, last_we_cyc + 1);
    end
    n_vec++;
    if ({done, cpu_run, error, busy} !== 4'b1100) begin
      n_err++;
      $display("FAIL basic_status: got done/run/err/busy=%b want 1100", {done, cpu_run, error, busy});
    end
    n_vec++;
    if (checksum !== exp_sum(2)) begin n_err++; $display("FAIL basic_checksum: got %0h want %0h", checksum, exp_sum(2)); end
  endtask

  task automatic test_backpressure();
    bit ok;
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    do_load(3, 45, 1'b1, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL bp_timeout: got done=%b want 1", ok); end
    n_vec++;
    if (wa_q.size() !== 12) begin n_err++; $display("FAIL bp_count: got %0d want 12", wa_q.size()); end
    n_vec++;
    if (bad_writes(3) !== 0) begin n_err++; $display("FAIL bp_bytes: got %0d bad writes want 0", bad_writes(3)); end
    n_vec++;
    if (overlap_cnt !== 0) begin n_err++; $display("FAIL bp_ready_in_write: got %0d cycles want 0", overlap_cnt); end
    n_vec++;
    if (checksum !== exp_sum(3)) begin n_err++; $display("FAIL bp_checksum: got %0h want %0h", checksum, exp_sum(3)); end
  endtask

  task automatic test_bounds();
    bit ok;
    for (int i = 0; i < CAP; i++) img[i] = $urandom;
    do_load(CAP, 100, 1'b0, ok);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL full_timeout: got done=%b want 1", ok); end
    n_vec++;
    if (wa_q.size() !== 4 * CAP) begin n_err++; $display("FAIL full_count: got %0d want %0d", wa_q.size(), 4 * CAP); end
    n_vec++;
    if (bad_writes(CAP) !== 0) begin n_err++; $display("FAIL full_bytes: got %0d bad writes want 0", bad_writes(CAP)); end
    n_vec++;
    if (wa_q[wa_q.size()-1] !== AW'(1023)) begin
      n_err++;
      $display("FAIL full_last_addr: got %0d want 1023", wa_q[wa_q.size()-1]);
    end
    n_vec++;
    if (done_cyc !== last_we_cyc + 1) begin
      n_err++;
      $display("FAIL full_done_latency: got cycle %0d want %0d", done_cyc, last_we_cyc + 1);
    end
    n_vec++;
    if (checksum !== exp_sum(CAP)) begin n_err++; $display("FAIL full_checksum: got %0h want %0h", checksum, exp_sum(CAP)); end

    wa_q.delete();
    wd_q.delete();
    start        = 1'b1;
    length_words = (AW-1)'(CAP + 1);
    @(negedge clk);
    start        = 1'b0;
    mif.in_valid = 1'b1;
    mif.in_data  = $urandom;
    n_vec++;
    if ({error, done, cpu_run, busy} !== 4'b1010) begin
      n_err++;
      $display("FAIL over_status: got err/done/run/busy=%b want 1010", {error, done, cpu_run, busy});
    end
    repeat (4) @(negedge clk);
    mif.in_valid = 1'b0;
    n_vec++;
    if (wa_q.size() !== 0) begin n_err++; $display("FAIL over_writes: got %0d want 0", wa_q.size()); end
    n_vec++;
    if ({error, done, cpu_run, mif.in_ready} !== 4'b1010) begin
      n_err++;
      $display("FAIL over_hold: got err/done/run/rdy=%b want 1010", {error, done, cpu_run, mif.in_ready});
    end
  endtask

  task automatic test_zero_length();
    bit ok;
    wa_q.delete();
    wd_q.delete();
    start        = 1'b1;
    length_words = '0;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if ({done, cpu_run, error, busy} !== 4'b1100) begin
      n_err++;
      $display("FAIL zero_status: got done/run/err/busy=%b want 1100", {done, cpu_run, error, busy});
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (wa_q.size() !== 0) begin n_err++; $display("FAIL zero_writes: got %0d want 0", wa_q.size()); end
    img[0] = $urandom;
    do_load(1, 70, 1'b0, ok);
    n_vec++;
    if (ok !== 1'b1 || bad_writes(1) !== 0 || wa_q.size() !== 4) begin
      n_err++;
      $display("FAIL zero_reload: got ok=%b writes=%0d bad=%0d want 1/4/0", ok, wa_q.size(), bad_writes(1));
    end
    n_vec++;
    if (runbusy_cnt !== 0 || cpu_low_cnt < 5) begin
      n_err++;
      $display("FAIL zero_cpu_run_drop: got run-while-busy=%0d low-cycles=%0d want 0/>=5", runbusy_cnt, cpu_low_cnt);
    end
    n_vec++;
    if (cpu_run !== 1'b1) begin n_err++; $display("FAIL zero_cpu_run_back: got %b want 1", cpu_run); end
  endtask

  task automatic test_reset_midop();
    bit ok;
    wa_q.delete();
    wd_q.delete();
    start        = 1'b1;
    length_words = (AW-1)'(1);
    @(negedge clk);
    start        = 1'b0;
    mif.in_valid = 1'b1;
    mif.in_data  = 32'hA5C3_5A3C;
    @(negedge clk);
    mif.in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (wa_q.size() !== 2) begin n_err++; $display("FAIL midop_pre_writes: got %0d want 2", wa_q.size()); end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({mif.in_ready, mif.mem_we, mif.mem_addr, mif.mem_wdata, busy, done, error, cpu_run, checksum} !== '0) begin
      n_err++;
      $display("FAIL midop_async_reset: got rdy=%b we=%b addr=%0h wd=%0h busy=%b done=%b err=%b run=%b sum=%0h want all 0",
               mif.in_ready, mif.mem_we, mif.mem_addr, mif.mem_wdata, busy, done, error, cpu_run, checksum);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    img[0] = $urandom;
    do_load(1, 100, 1'b0, ok);
    n_vec++;
    if (ok !== 1'b1 || wa_q.size() !== 4 || bad_writes(1) !== 0) begin
      n_err++;
      $display("FAIL midop_reload: got ok=%b writes=%0d bad=%0d want 1/4/0", ok, wa_q.size(), bad_writes(1));
    end
  endtask

  task automatic test_checksum();
    bit ok;
    logic [31:0] want;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    want = 32'h0000_0001;
`else
    want = 32'h0000_0000;
`endif
    img[0] = 32'hFFFF_FFFF;
    img[1] = 32'h0000_0002;
    do_load(2, 80, 1'b0, ok);
    n_vec++;
    if (ok !== 1'b1 || checksum !== want) begin
      n_err++;
      $display("FAIL checksum_wrap: got ok=%b sum=%0h want 1/%0h", ok, checksum, want);
    end
  endtask

  task automatic test_random_loads();
    bit ok;
    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(6, 1);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      do_load(n, $urandom_range(100, 30), t[0], ok);
      n_vec++;
      if (ok !== 1'b1 || wa_q.size() !== 4 * n || bad_writes(n) !== 0) begin
        n_err++;
        $display("FAIL rand_load%0d: got ok=%b writes=%0d bad=%0d want 1/%0d/0", t, ok, wa_q.size(), bad_writes(n), 4 * n);
      end
      n_vec++;
      if (checksum !== exp_sum(n) || overlap_cnt !== 0 || runbusy_cnt !== 0) begin
        n_err++;
        $display("FAIL rand_status%0d: got sum=%0h overlap=%0d runbusy=%0d want %0h/0/0",
                 t, checksum, overlap_cnt, runbusy_cnt, exp_sum(n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bounds();
    test_zero_length();
    test_reset_midop();
    test_checksum();
    test_random_loads();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
